// File: rtl/nn_inference_host.sv
// Host-side sequencer for the NN accelerator: buffers one input frame, starts the
// accelerator, argmax-reduces its outputs, hands the class out and resets the accelerator.
module nn_inference_host #(
    parameter int NUM_INPUTS     = 256,
    parameter int NUM_OUTPUTS    = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [7:0]                             in_data,
    output logic                                   in_ready,
    output logic [NUM_INPUTS-1:0][7:0]             acc_inputs,
    output logic                                   acc_start,
    output logic                                   acc_rst,
    input  logic                                   acc_done,
    input  logic signed [NUM_OUTPUTS-1:0][15:0]    acc_activations,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [$clog2(NUM_OUTPUTS)-1:0]         res_class,
    output logic signed [15:0]                     res_score,
    output logic                                   busy,
    output logic                                   err
);
    localparam int IW = $clog2(NUM_INPUTS);
    localparam int OW = $clog2(NUM_OUTPUTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IN_LAST  = IW'(NUM_INPUTS - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(NUM_OUTPUTS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {LOAD, START, WAIT, SCAN, RESULT, CLEAR} state_t;

    state_t                     state, state_nxt;
    logic [NUM_INPUTS-1:0][7:0] frame_buf;
    logic [IW-1:0]              wr_idx;
    logic [OW-1:0]              scan_idx;
    logic [TW-1:0]              tcnt;
    logic [OW-1:0]              best_idx;
    logic signed [15:0]         best_val;
    logic signed [15:0]         cur_act;

    assign cur_act    = acc_activations[scan_idx];
    assign acc_inputs = frame_buf;
    assign res_class  = best_idx;
    assign res_score  = best_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        acc_start = 1'b0;
        acc_rst   = 1'b0;
        res_valid = 1'b0;
        busy      = (state != LOAD);
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && wr_idx == IN_LAST) state_nxt = START;
            end
            START: begin
                acc_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // done has priority over a coincident timeout
                if (acc_done)             state_nxt = SCAN;
                else if (tcnt == TO_LAST) state_nxt = CLEAR;
            end
            SCAN: if (scan_idx == OUT_LAST) state_nxt = RESULT;
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = CLEAR;
            end
            CLEAR: begin
                acc_rst   = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_buf <= '0;
            wr_idx    <= '0;
            scan_idx  <= '0;
            tcnt      <= '0;
            best_idx  <= '0;
            best_val  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    frame_buf[wr_idx] <= in_data;
                    wr_idx            <= (wr_idx == IN_LAST) ? '0 : wr_idx + IW'(1);
                end
                START: tcnt <= '0;
                WAIT: begin
                    if (acc_done)             scan_idx <= '0;
                    else if (tcnt == TO_LAST) err      <= 1'b1;
                    else                      tcnt     <= tcnt + TW'(1);
                end
                SCAN: begin
                    // strict compare keeps the lowest index on ties
                    if (scan_idx == '0 || cur_act > best_val) begin
                        best_val <= cur_act;
                        best_idx <= scan_idx;
                    end
                    scan_idx <= (scan_idx == OUT_LAST) ? '0 : scan_idx + OW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nn_inference_host.sv
// Directed bench for nn_inference_host: two instances (default timeout and a short
// 64-cycle timeout) sharing stimulus, with the active one chosen by sel.
module tb_nn_inference_host;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, sel, in_valid, acc_done, res_ready;
    logic [7:0]               in_data;
    logic signed [9:0][15:0]  acts;
    int                       errors = 0, checks = 0;

    logic ir1, as1, ar1, rv1, bz1, er1, ir2, as2, ar2, rv2, bz2, er2;
    logic [255:0][7:0] ai1, ai2;
    logic [3:0] rc1, rc2;
    logic signed [15:0] rs1, rs2;

    nn_inference_host dut (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(ir1),
        .acc_inputs(ai1), .acc_start(as1), .acc_rst(ar1), .acc_done(acc_done & ~sel),
        .acc_activations(acts), .res_valid(rv1), .res_ready(res_ready & ~sel),
        .res_class(rc1), .res_score(rs1), .busy(bz1), .err(er1));

    nn_inference_host #(.TIMEOUT_CYCLES(64)) dut_to (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_data(in_data), .in_ready(ir2),
        .acc_inputs(ai2), .acc_start(as2), .acc_rst(ar2), .acc_done(acc_done & sel),
        .acc_activations(acts), .res_valid(rv2), .res_ready(res_ready & sel),
        .res_class(rc2), .res_score(rs2), .busy(bz2), .err(er2));

    logic m_ir, m_as, m_ar, m_rv, m_bz, m_er;
    logic [255:0][7:0] m_ai;
    logic [3:0] m_rc;
    logic signed [15:0] m_rs;
    assign m_ir = sel ? ir2 : ir1;
    assign m_as = sel ? as2 : as1;
    assign m_ar = sel ? ar2 : ar1;
    assign m_rv = sel ? rv2 : rv1;
    assign m_bz = sel ? bz2 : bz1;
    assign m_er = sel ? er2 : er1;
    assign m_ai = sel ? ai2 : ai1;
    assign m_rc = sel ? rc2 : rc1;
    assign m_rs = sel ? rs2 : rs1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; acc_done = 1'b0; res_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Streams base..base+255; ends at the negedge of the START cycle.
    task automatic load_frame(input logic [7:0] base, input bit gaps);
        bit early = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    if (m_as) early = 1'b1;
                end
            end
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            @(negedge clk);
            if (i < 255 && m_as) early = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (early !== 1'b0) begin errors++; $display("FAIL start_early: acc_start seen before final beat"); end
        checks++;
        if ({m_as, m_bz, m_ir} !== 3'b110) begin
            errors++; $display("FAIL start_pulse: start/busy/in_ready=%b want 110", {m_as, m_bz, m_ir});
        end
    endtask

    // Called at the START negedge; runs accelerator latency, result and return to LOAD.
    task automatic finish_frame(input int lat, input logic [7:0] base, input logic [3:0] cls,
                                input logic signed [15:0] score, input int hold, input bit poke);
        logic [255:0][7:0] exp_buf;
        int n;
        bit bad;
        for (int i = 0; i < 256; i++) exp_buf[i] = base + 8'(i);
        @(negedge clk);
        checks++;
        if (m_as !== 1'b0) begin errors++; $display("FAIL start_single: acc_start=%b want 0", m_as); end
        checks++;
        if (m_ai !== exp_buf) begin errors++; $display("FAIL buf_wait: acc_inputs[0]=%0h want %0h", m_ai[0], exp_buf[0]); end
        for (int c = 0; c < lat - 1; c++) begin
            in_data  = 8'hFF;
            in_valid = poke ? ~in_valid : 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        n = 1;
        while (!m_rv && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n !== 11) begin errors++; $display("FAIL res_latency: %0d cycles want 11", n); end
        checks++;
        if (m_rc !== cls || m_rs !== score) begin
            errors++; $display("FAIL result: class=%0d score=%0h want class=%0d score=%0h", m_rc, m_rs, cls, score);
        end
        bad = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (m_rv !== 1'b1 || m_rc !== cls || m_rs !== score || m_ir !== 1'b0 || m_ar !== 1'b0) bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (bad !== 1'b0) begin errors++; $display("FAIL backpressure: outputs moved while res_ready=0 (got 1 want 0)"); end
        end
        checks++;
        if (m_ai !== exp_buf) begin errors++; $display("FAIL buf_result: acc_inputs[255]=%0h want %0h", m_ai[255], exp_buf[255]); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if ({m_ar, m_ir, m_rv} !== 3'b100) begin
            errors++; $display("FAIL clear: acc_rst/in_ready/res_valid=%b want 100", {m_ar, m_ir, m_rv});
        end
        @(negedge clk);
        checks++;
        if ({m_ar, m_ir, m_bz} !== 3'b010) begin
            errors++; $display("FAIL reload: acc_rst/in_ready/busy=%b want 010", {m_ar, m_ir, m_bz});
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; in_valid = 1'b0; acc_done = 1'b0; res_ready = 1'b0; in_data = '0; acts = '0;
        @(negedge clk);
        checks++;
        if ({m_ir, m_as, m_ar, m_rv, m_bz, m_er} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl: %b want 100000", {m_ir, m_as, m_ar, m_rv, m_bz, m_er});
        end
        checks++;
        if (m_rc !== 4'd0 || m_rs !== 16'sd0) begin errors++; $display("FAIL reset_result: class=%0d score=%0h want 0 0", m_rc, m_rs); end
        checks++;
        if (m_ai !== '0) begin errors++; $display("FAIL reset_buf: acc_inputs nonzero want 0"); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        acts = '0; acts[7] = 16'sh4000;
        load_frame(8'h00, 1'b0);
        finish_frame(385, 8'h00, 4'd7, 16'sh4000, 0, 1'b0);
        checks++;
        if (m_er !== 1'b0) begin errors++; $display("FAIL basic_err: err=%b want 0", m_er); end
    endtask

    task automatic test_tie();
        for (int k = 0; k < 10; k++) acts[k] = 16'sh1000;
        acts[2] = 16'sh7FFF; acts[5] = 16'sh7FFF;
        load_frame(8'h55, 1'b0);
        finish_frame(20, 8'h55, 4'd2, 16'sh7FFF, 0, 1'b0);
    endtask

    task automatic test_negative();
        for (int k = 0; k < 10; k++) acts[k] = 16'(-5 - k);
        load_frame(8'hA0, 1'b0);
        finish_frame(12, 8'hA0, 4'd0, -16'sd5, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) acts[k] = -16'sd1;
        acts[9] = 16'sh0100;
        load_frame(8'h07, 1'b0);
        finish_frame(30, 8'h07, 4'd9, 16'sh0100, 20, 1'b0);
    endtask

    task automatic test_midload_reset();
        for (int k = 0; k < 10; k++) acts[k] = 16'sh1FFF;
        acts[4] = 16'sh2000;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'hAA;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (m_ai !== '0 || m_ir !== 1'b1) begin errors++; $display("FAIL async_reset: buf/in_ready not cleared (in_ready=%b want 1)", m_ir); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load_frame(8'h10, 1'b1);
        finish_frame(40, 8'h10, 4'd4, 16'sh2000, 0, 1'b1);
    endtask

    task automatic test_timeout();
        bit rv_seen = 1'b0;
        sel = 1'b1;
        do_reset();
        load_frame(8'h30, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (m_rv) rv_seen = 1'b1;
        end
        checks++;
        if ({m_er, m_bz, m_ar} !== 3'b010) begin errors++; $display("FAIL to_wait: err/busy/acc_rst=%b want 010", {m_er, m_bz, m_ar}); end
        @(negedge clk);
        if (m_rv) rv_seen = 1'b1;
        checks++;
        if ({m_er, m_ar, m_ir} !== 3'b110) begin errors++; $display("FAIL to_fire: err/acc_rst/in_ready=%b want 110", {m_er, m_ar, m_ir}); end
        @(negedge clk);
        if (m_rv) rv_seen = 1'b1;
        checks++;
        if ({m_ar, m_ir} !== 2'b01) begin errors++; $display("FAIL to_reload: acc_rst/in_ready=%b want 01", {m_ar, m_ir}); end
        checks++;
        if (rv_seen !== 1'b0) begin errors++; $display("FAIL to_no_result: res_valid seen=1 want 0"); end
        for (int k = 0; k < 10; k++) acts[k] = 16'(k);
        load_frame(8'h40, 1'b0);
        finish_frame(5, 8'h40, 4'd9, 16'sd9, 0, 1'b0);
        checks++;
        if (m_er !== 1'b1) begin errors++; $display("FAIL to_sticky: err=%b want 1", m_er); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_negative();
        test_back_to_back();
        test_midload_reset();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
